// File: rtl/snake_key_scheduler.sv
// snake_key_scheduler: decodes PS/2 bytes into snake direction/pause/restart commands and queues directions per game tick.
// Optional WASD steering is enabled by defining SNAKE_KEY_WASD_EN.
module snake_key_scheduler #(
    parameter int         QDEPTH   = 2,
    parameter logic [1:0] INIT_DIR = 2'b11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] keycode,
    input  logic        game_tick,
    output logic [1:0]  dir,
    output logic        dir_changed,
    output logic        paused,
    output logic        restart,
    output logic [2:0]  q_count
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
    state_t state, state_nx;
    logic [31:0] keycode_q;
    logic [1:0]  q [QDEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, tail_ptr;
    logic ev, req_v, tog, rst_cmd, pop, push, full, same_axis, same;
    logic [7:0] b;
    logic [1:0] req_d, ref_d;
    assign ev = keycode != keycode_q;
    assign b  = keycode[7:0];
    always_comb begin
        state_nx = state;
        req_v    = 1'b0;
        req_d    = 2'b00;
        tog      = 1'b0;
        rst_cmd  = 1'b0;
        if (ev) begin
            case (state)
                IDLE: begin
                    case (b)
                        8'hE0: state_nx = EXT;
                        8'hF0: state_nx = BRK;
                        8'h29: tog = 1'b1;
                        8'h5A: rst_cmd = 1'b1;
`ifdef SNAKE_KEY_WASD_EN
                        8'h1D: begin req_v = 1'b1; req_d = 2'b00; end
                        8'h1B: begin req_v = 1'b1; req_d = 2'b01; end
                        8'h1C: begin req_v = 1'b1; req_d = 2'b10; end
                        8'h23: begin req_v = 1'b1; req_d = 2'b11; end
`endif
                        default: ;
                    endcase
                end
                EXT: begin
                    state_nx = (b == 8'hF0) ? EXT_BRK : IDLE;
                    case (b)
                        8'h75: begin req_v = 1'b1; req_d = 2'b00; end
                        8'h72: begin req_v = 1'b1; req_d = 2'b01; end
                        8'h6B: begin req_v = 1'b1; req_d = 2'b10; end
                        8'h74: begin req_v = 1'b1; req_d = 2'b11; end
                        default: ;
                    endcase
                end
                default: state_nx = IDLE;
            endcase
        end
    end
    // Requests are filtered against the last thing the snake will do: the queue tail, or dir when empty.
    assign tail_ptr  = (wr_ptr == '0) ? PW'(QDEPTH - 1) : wr_ptr - 1'b1;
    assign ref_d     = (q_count != 3'd0) ? q[tail_ptr] : dir;
    assign same_axis = req_d[1] == ref_d[1];
    assign same      = req_d == ref_d;
    assign full      = q_count == 3'(QDEPTH);
    assign pop       = game_tick && !paused && (q_count != 3'd0) && !rst_cmd;
    assign push      = req_v && !(same_axis && !same) && !same && (!full || pop);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            keycode_q   <= '0;
            dir         <= INIT_DIR;
            dir_changed <= 1'b0;
            paused      <= 1'b0;
            restart     <= 1'b0;
            q_count     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            q           <= '{default: '0};
        end else begin
            state       <= state_nx;
            keycode_q   <= keycode;
            dir_changed <= pop;
            restart     <= rst_cmd;
            paused      <= rst_cmd ? 1'b0 : paused ^ tog;
            if (pop) dir <= q[rd_ptr];
            if (rst_cmd) begin
                q_count <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
            end else begin
                q_count <= q_count + 3'(push) - 3'(pop);
                if (pop) rd_ptr <= (rd_ptr == PW'(QDEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                if (push) begin
                    q[wr_ptr] <= req_d;
                    wr_ptr    <= (wr_ptr == PW'(QDEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_snake_key_scheduler.sv
// tb_snake_key_scheduler: directed vector table plus randomized bytes checked against a queue-based reference model.
module tb_snake_key_scheduler;
    localparam int QD = 2;
`ifdef SNAKE_KEY_WASD_EN
    localparam bit W = 1'b1;
`else
    localparam bit W = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
    logic [31:0] kc = '0;
    logic [1:0] dir;
    logic dir_changed, paused, restart;
    logic [2:0] q_count;
    logic [7:0] dp;
    int checks = 0, errors = 0;

    snake_key_scheduler #(.QDEPTH(QD), .INIT_DIR(2'b11)) dut (
        .clk(clk), .rst_n(rst_n), .keycode(kc), .game_tick(tick),
        .dir(dir), .dir_changed(dir_changed), .paused(paused),
        .restart(restart), .q_count(q_count)
    );

    always #5 clk = ~clk;
    assign dp = {dir, dir_changed, paused, restart, q_count};

    logic [31:0] m_kq;
    logic m_ext, m_brk, m_chg, m_pau, m_rst;
    logic [1:0] m_dir;
    logic [1:0] mq[$];

    typedef struct {bit sh; logic [7:0] b; bit t; logic [7:0] e;} vec_t;
    vec_t tv[$];

    task automatic model_reset();
        m_kq = '0; m_ext = 0; m_brk = 0; m_chg = 0; m_pau = 0; m_rst = 0;
        m_dir = 2'b11; mq.delete();
    endtask

    function automatic logic [7:0] mpack();
        return {m_dir, m_chg, m_pau, m_rst, 3'(mq.size())};
    endfunction

    function automatic logic [2:0] arrow(logic [7:0] b);
        return b == 8'h75 ? 3'b100 : b == 8'h72 ? 3'b101 : b == 8'h6B ? 3'b110 : b == 8'h74 ? 3'b111 : 3'b000;
    endfunction

    function automatic logic [2:0] wasd(logic [7:0] b);
        return b == 8'h1D ? 3'b100 : b == 8'h1B ? 3'b101 : b == 8'h1C ? 3'b110 : b == 8'h23 ? 3'b111 : 3'b000;
    endfunction

    task automatic step_model();
        logic [7:0] b;
        logic req, tg, rc, pop, push, full;
        logic [1:0] rd, rf;
        b = kc[7:0]; req = 0; rd = 0; tg = 0; rc = 0;
        if (kc != m_kq) begin
            if (m_brk) m_brk = 0;
            else if (m_ext) begin
                m_ext = 0;
                m_brk = (b == 8'hF0);
                {req, rd} = arrow(b);
            end
            else if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else if (b == 8'h29) tg = 1;
            else if (b == 8'h5A) rc = 1;
            else if (W) {req, rd} = wasd(b);
        end
        rf   = (mq.size() > 0) ? mq[$] : m_dir;
        full = mq.size() == QD;
        pop  = tick && !m_pau && mq.size() > 0 && !rc;
        push = req && rd != rf && !(rd[1] == rf[1] && rd[0] != rf[0]) && (!full || pop);
        m_chg = pop;
        if (pop) m_dir = mq.pop_front();
        if (push) mq.push_back(rd);
        m_rst = rc;
        if (rc) begin mq.delete(); m_pau = 0; end
        else m_pau = m_pau ^ tg;
        m_kq = kc;
    endtask

    task automatic chk(string n, logic [7:0] got, logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got {dir,chg,pau,rst,qc}=%b_%b_%b_%b_%0d exp %b_%b_%b_%b_%0d",
                     n, got[7:6], got[5], got[4], got[3], got[2:0], exp[7:6], exp[5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    task automatic cyc(string n);
        @(posedge clk);
        step_model();
        #1;
        chk(n, dp, mpack());
    endtask

    task automatic add(bit sh, logic [7:0] b, bit t, logic [1:0] d, bit c, bit p, bit r, logic [2:0] q);
        vec_t v;
        v.sh = sh; v.b = b; v.t = t; v.e = {d, c, p, r, q};
        tv.push_back(v);
    endtask

    initial begin
        logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h5A, 8'h1D, 8'h1B, 8'h1C, 8'h23};
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk("reset", dp, 8'b11_0_0_0_000);
        @(negedge clk) rst_n = 1'b1;

        add(1, 8'hE0, 0, 2'b11, 0, 0, 0, 0);
        add(1, 8'h75, 0, 2'b11, 0, 0, 0, 1);
        add(0, 8'h00, 1, 2'b00, 1, 0, 0, 0);
        add(0, 8'h00, 0, 2'b00, 0, 0, 0, 0);
        add(1, 8'hE0, 0, 2'b00, 0, 0, 0, 0);
        add(1, 8'h72, 0, 2'b00, 0, 0, 0, 0);
        add(0, 8'h00, 1, 2'b00, 0, 0, 0, 0);
        add(1, 8'hE0, 0, 2'b00, 0, 0, 0, 0);
        add(1, 8'h74, 0, 2'b00, 0, 0, 0, 1);
        add(1, 8'hE0, 0, 2'b00, 0, 0, 0, 1);
        add(1, 8'h72, 0, 2'b00, 0, 0, 0, 2);
        add(1, 8'hE0, 0, 2'b00, 0, 0, 0, 2);
        add(1, 8'h6B, 0, 2'b00, 0, 0, 0, 2);
        add(0, 8'h00, 1, 2'b11, 1, 0, 0, 1);
        add(0, 8'h00, 1, 2'b01, 1, 0, 0, 0);
        add(0, 8'h00, 0, 2'b01, 0, 0, 0, 0);
        add(1, 8'hE0, 0, 2'b01, 0, 0, 0, 0);
        add(1, 8'hF0, 0, 2'b01, 0, 0, 0, 0);
        add(1, 8'h75, 0, 2'b01, 0, 0, 0, 0);
        add(1, 8'h29, 0, 2'b01, 0, 1, 0, 0);
        add(1, 8'hE0, 0, 2'b01, 0, 1, 0, 0);
        add(1, 8'h6B, 0, 2'b01, 0, 1, 0, 1);
        add(1, 8'hE0, 0, 2'b01, 0, 1, 0, 1);
        add(1, 8'h75, 0, 2'b01, 0, 1, 0, 2);
        add(0, 8'h00, 1, 2'b01, 0, 1, 0, 2);
        add(1, 8'h5A, 0, 2'b01, 0, 0, 1, 0);
        add(0, 8'h00, 0, 2'b01, 0, 0, 0, 0);
        add(1, 8'hE0, 0, 2'b01, 0, 0, 0, 0);
        add(1, 8'h6B, 0, 2'b01, 0, 0, 0, 1);
        add(1, 8'hE0, 0, 2'b01, 0, 0, 0, 1);
        add(1, 8'h75, 0, 2'b01, 0, 0, 0, 2);
        add(1, 8'hE0, 0, 2'b01, 0, 0, 0, 2);
        add(1, 8'h74, 1, 2'b10, 1, 0, 0, 2);
        add(0, 8'h00, 1, 2'b00, 1, 0, 0, 1);
        add(0, 8'h00, 1, 2'b11, 1, 0, 0, 0);
        add(1, 8'h1D, 0, 2'b11, 0, 0, 0, 3'(W));
        add(0, 8'h00, 1, W ? 2'b00 : 2'b11, W, 0, 0, 0);
        add(1, 8'hF0, 0, W ? 2'b00 : 2'b11, 0, 0, 0, 0);
        add(1, 8'h1D, 0, W ? 2'b00 : 2'b11, 0, 0, 0, 0);

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].sh) kc = {kc[23:0], tv[i].b};
            tick = tv[i].t;
            cyc($sformatf("model_vec%0d", i));
            chk($sformatf("vec%0d", i), dp, tv[i].e);
            tick = 1'b0;
        end

        for (int i = 0; i < 600; i++) begin
            logic [7:0] nb;
            nb = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
            if ((nb == 8'h29 || nb == 8'h5A) && $urandom_range(0, 2) != 0) nb = 8'hE0;
            if ($urandom_range(0, 4) != 0) kc = {kc[23:0], nb};
            tick = ($urandom_range(0, 9) < 3);
            cyc("rand");
            tick = 1'b0;
        end

        kc = {kc[23:0], 8'hE0};
        cyc("pre_rst");
        @(negedge clk) rst_n = 1'b0;
        #1 chk("async_rst", dp, 8'b11_0_0_0_000);
        model_reset();
        kc = '0;
        @(negedge clk) rst_n = 1'b1;
        cyc("post_rst_quiet");
        kc = 32'h0000_0075;
        cyc("post_rst_model");
        chk("post_rst_idle", dp, 8'b11_0_0_0_000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/snake_key_scheduler.md
Name: snake_key_scheduler

Overview:
Sits between the PS/2 receiver and the snake game engine. Watches the receiver's 32-bit keycode shift word and detects each newly received byte. Decodes make, break (F0) and extended (E0) sequences into direction, pause and restart commands. Queues direction requests, filters out reversals and duplicates, and releases one queued direction per game tick.

Parameters:
QDEPTH, 2, direction queue depth; legal values 1..4.
INIT_DIR, 2'b11, direction loaded at reset (RIGHT).

Ports:
clk  input  1  system clock; keycode is synchronous to it
rst_n  input  1  asynchronous active-low reset
keycode  input  32  receiver keycode word; newest byte in [7:0], older bytes shifted up
game_tick  input  1  one-cycle pulse; the snake advances one cell
dir  output  2  committed direction: 00 up, 01 down, 10 left, 11 right
dir_changed  output  1  one-cycle pulse when dir takes a new value
paused  output  1  pause level, toggled by space
restart  output  1  one-cycle restart pulse, on Enter
q_count  output  3  number of valid queue entries

Behaviour:
- Reset (async, rst_n=0) values: dir=INIT_DIR, dir_changed=0, paused=0, restart=0, q_count=0, queue empty, decoder in IDLE, keycode_q=0.
- Byte detect: keycode_q registers keycode each cycle. A byte event fires when keycode != keycode_q; the event byte is keycode[7:0].
  - Decode happens in the detect cycle. Effects (enqueue, paused, restart) are registered at the next edge, so latency is 1 cycle after keycode changes.
- Decoder FSM, advanced only on byte events:
  - IDLE: E0 -> EXT; F0 -> BRK; 29 -> toggle paused; 5A -> restart pulse; otherwise apply the non-extended map (see Optional Feature); stay in IDLE.
  - EXT: F0 -> EXT_BRK; 75 up, 72 down, 6B left, 74 right -> direction request; any byte returns to IDLE.
  - BRK: byte consumed with no effect -> IDLE.
  - EXT_BRK: byte consumed with no effect -> IDLE.
- Direction request filter, reference = queue tail if q_count>0, else dir:
  - Reversal (same bit[1], different bit[0]) -> dropped.
  - Equal to reference -> dropped.
  - Queue full and no pop this cycle -> dropped.
  - Otherwise enqueue.
- Pop: on game_tick with paused=0 and q_count>0:
  - dir <= head; dir_changed=1 for that cycle; entry removed.
  - game_tick while paused, or with an empty queue -> no change, dir_changed=0.
- Simultaneous events:
  - Pop and enqueue in the same cycle are both performed; q_count is unchanged. A full queue accepts the new entry.
  - With an empty queue, the filter reference is dir (pre-pop), never the incoming request.
- restart: pulses once; also flushes the queue (q_count=0) and clears paused. dir is not changed.
- Queue is a circular buffer; read/write pointers wrap modulo QDEPTH. q_count never exceeds QDEPTH.
- Known limitation: identical consecutive bytes that leave keycode unchanged are not detected. Typematic repeats of a held key may be missed, which is acceptable.

Optional Feature:
Macro SNAKE_KEY_WASD_EN.
- Defined: in IDLE, non-extended 1D=up, 1B=down, 1C=left, 23=right produce direction requests.
- Not defined: only E0-prefixed arrow keys steer; 1D/1B/1C/23 are ignored.
- Both builds: F0-prefixed WASD bytes are consumed by BRK, never acted on.

Test Plan:
- Reset then keycode sequence 0x00000000 -> 0x000000E0 -> 0x0000E075 -> game_tick -> q_count 1 after the 75 byte; dir=00, dir_changed=1 on the tick cycle only.
- dir=11 (right), send E0 6B (left) -> request dropped, q_count stays 0; tick leaves dir=11, dir_changed=0.
- Send E0 75 then E0 6B (up, left) with QDEPTH=2 -> q_count=2. Third request E0 72 dropped. Two ticks -> dir 00 then 10.
- Break sequence E0 F0 75 -> no enqueue, FSM back in IDLE. A following 29 -> paused=1; a tick with q_count>0 does not pop.
- Byte 5A with q_count=2 and paused=1 -> restart=1 for one cycle, q_count=0, paused=0, dir unchanged.
- SNAKE_KEY_WASD_EN defined, byte 1D from dir=11 -> enqueued up. Without the macro -> ignored. Deassert rst_n mid-sequence (after E0) -> all outputs at reset values immediately, FSM in IDLE.
